// File: rtl/apb_arbiter.sv
// Two-requester APB master with round-robin arbitration.
// A PREADY wait beyond TIMEOUT ACCESS cycles aborts the transfer and reports err.
module apb_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        req0,
    input  logic        req1,
    input  logic        rw0,
    input  logic        rw1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL1,
    output logic        PSEL2,
    input  logic        PREADY,
    input  logic [31:0] PRDATA
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_reg, state_next;
    logic        owner_reg;
    logic        last_gnt_reg;
    logic        pwrite_reg;
    logic [31:0] paddr_reg;
    logic [31:0] pwdata_reg;
    logic [31:0] rdata_reg;
    logic [7:0]  wait_cnt_reg;
    logic [1:0]  done_vec_reg;
    logic [1:0]  err_vec_reg;

    logic [1:0]  req_vec;
    logic [1:0]  elig;
    logic [1:0]  gnt_vec;
    logic        pick;
    logic        start;
    logic        ready_end;
    logic        timeout_end;
    logic        complete;

    assign req_vec = {req1, req0};

    // A requester whose done pulse is showing this cycle sits out one arbitration.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign elig[gi]    = req_vec[gi] & ~done_vec_reg[gi];
            assign gnt_vec[gi] = (state_reg != IDLE) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign pick        = (elig[0] & elig[1]) ? ~last_gnt_reg : elig[1];
    assign start       = (state_reg == IDLE) && (elig != 2'b00);
    assign ready_end   = (state_reg == ACCESS) && PREADY;
    assign timeout_end = (state_reg == ACCESS) && !PREADY && (wait_cnt_reg == WAIT_LAST);
    assign complete    = ready_end | timeout_end;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            last_gnt_reg <= 1'b1;
            pwrite_reg   <= 1'b0;
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
            rdata_reg    <= '0;
            wait_cnt_reg <= '0;
            done_vec_reg <= '0;
            err_vec_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            done_vec_reg <= {complete & owner_reg, complete & ~owner_reg};
            err_vec_reg  <= {timeout_end & owner_reg, timeout_end & ~owner_reg};

            if (start) begin
                owner_reg    <= pick;
                last_gnt_reg <= pick;
                pwrite_reg   <= pick ? ~rw1 : ~rw0;
                paddr_reg    <= pick ? addr1 : addr0;
                pwdata_reg   <= pick ? wdata1 : wdata0;
            end

            if (state_reg == SETUP) begin
                wait_cnt_reg <= '0;
            end else if ((state_reg == ACCESS) && !PREADY) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end

            // Writes leave rdata untouched; a timed-out read clears it.
            if (ready_end && !pwrite_reg) begin
                rdata_reg <= PRDATA;
            end else if (timeout_end && !pwrite_reg) begin
                rdata_reg <= '0;
            end
        end
    end

    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];
    assign done0   = done_vec_reg[0];
    assign done1   = done_vec_reg[1];
    assign err0    = err_vec_reg[0];
    assign err1    = err_vec_reg[1];
    assign rdata   = rdata_reg;
    assign PADDR   = paddr_reg;
    assign PWDATA  = pwdata_reg;
    assign PWRITE  = pwrite_reg;
    assign PENABLE = (state_reg == ACCESS);
    assign PSEL1   = (state_reg != IDLE) && !paddr_reg[31];
    assign PSEL2   = (state_reg != IDLE) && paddr_reg[31];

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 16, the maximum number of ACCESS cycles with PREADY low before a transfer is aborted (range 2..255).
REQ-002 PCLK  in  1  single clock; all state updates on the rising edge.
REQ-003 PRESETn  in  1  asynchronous, active-low reset.
REQ-004 req0, req1  in  1  transfer request from requester 0 / 1; held high until that requester's done.
REQ-005 rw0, rw1  in  1  direction; 1 = read, 0 = write.
REQ-006 addr0, addr1  in  32  transfer address.
REQ-007 wdata0, wdata1  in  32  write data.
REQ-008 gnt0, gnt1  out  1  requester currently owns the APB bus.
REQ-009 done0, done1  out  1  one-cycle completion pulse.
REQ-010 err0, err1  out  1  valid with done; 1 = transfer timed out.
REQ-011 rdata  out  32  read data; valid with done of a read.
REQ-012 PADDR, PWDATA  out  32  APB address and write data.
REQ-013 PWRITE, PENABLE  out  1  APB direction and enable.
REQ-014 PSEL1, PSEL2  out  1  slave selects: GPIO (PSEL1) and UART (PSEL2).
REQ-015 PREADY  in  1; PRDATA  in  32  slave response.

Function
REQ-016 The block SHALL implement three states: IDLE, SETUP, ACCESS.
REQ-017 IDLE: if any eligible request is present, select one, latch its rw/addr/wdata into internal registers, go to SETUP; otherwise stay in IDLE.
REQ-018 Eligible: req high and the corresponding done not asserted in the same cycle.
REQ-019 Arbitration: round-robin. A single eligible requester wins. When both are eligible, the one not granted last wins. After reset, requester 0 wins the first tie.
REQ-020 SETUP: PSELx high, PENABLE = 0. Unconditionally go to ACCESS next cycle.
REQ-021 ACCESS: PSELx high, PENABLE = 1. With PREADY = 1, go to IDLE.
REQ-022 Slave select is decoded from latched address bit 31: 1 selects PSEL2, 0 selects PSEL1. Exactly one select is high in SETUP/ACCESS, none in IDLE.
REQ-023 PADDR, PWDATA and PWRITE (= ~latched rw) SHALL remain stable from SETUP through the last ACCESS cycle.
REQ-024 gntN SHALL be high in SETUP and ACCESS for the owning requester, low otherwise; gnt0 and gnt1 are never high together.
REQ-025 Wait counter (8 bit): cleared on entry to ACCESS, incremented each ACCESS cycle with PREADY = 0.
REQ-026 Timeout: when the counter equals TIMEOUT-1 and PREADY = 0, abort and go to IDLE with err = 1.
REQ-027 PREADY = 1 on the timeout cycle SHALL be a normal completion (err = 0).
REQ-028 Completion: doneN (and errN) SHALL be registered and high for exactly one cycle, namely the IDLE cycle following the last ACCESS cycle.
REQ-029 rdata: on a read completion, capture PRDATA at the completing ACCESS edge. On a read timeout, load 0. On a write, leave it unchanged.
REQ-030 Minimum transfer time: 3 cycles (SETUP, ACCESS, IDLE). Back-to-back transfers SHALL alternate requesters when both hold req.
REQ-031 A change on req/rw/addr/wdata after the latch in IDLE SHALL NOT affect the transfer in progress.
REQ-032 A requester dropping req mid-transfer SHALL NOT abort it; done is still issued.

Reset
REQ-033 PRESETn low SHALL immediately force:
- state to IDLE; all outputs to 0, including rdata, PADDR and PWDATA
- the round-robin pointer to "last granted = 1"
- the wait counter to 0
REQ-034 Reset mid-transfer SHALL drop the transfer with no done/err pulse. The first edge after release evaluates IDLE normally.

Verification
REQ-035 Single write: req0 = 1, rw0 = 0, addr0 = 0x00000004, wdata0 = 0xA5A5A5A5, PREADY = 1 -> the following SHALL hold:
- SETUP with PSEL1 = 1, PWRITE = 1, PENABLE = 0
- then ACCESS with PENABLE = 1
- then done0 = 1, err0 = 0; 3 cycles total.
REQ-036 Read to UART: req1 = 1, rw1 = 1, addr1 = 0x80000000, PRDATA = 0x0000005A, PREADY low for 2 ACCESS cycles -> PSEL2 = 1, PWRITE = 0; done1 with rdata = 0x5A after 5 cycles.
REQ-037 Contention: req0 = req1 = 1 held continuously from reset -> grant order 0, 1, 0, 1; gnt never overlaps; each done pulse is exactly one cycle.
REQ-038 Timeout: TIMEOUT = 4, read, PREADY stuck 0 -> exactly 4 ACCESS cycles, then done = 1, err = 1, rdata = 0x00000000.
REQ-039 Reset in ACCESS: assert PRESETn = 0 mid-wait -> all outputs 0 asynchronously; no done. After release, a held req0 SHALL restart from SETUP.
